// File: rtl/x_23k640_arb_pkg.sv
// Shared types for the 23K640 SRAM request arbiter.
// Burst lock is enabled by defining X_23K640_ARB_BURST_LOCK_EN.
package x_23K640_pkg;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 32;

    typedef enum logic {ARB, HOLD} arb_state_t;

    typedef struct packed {
        logic              rd_n_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/x_23k640_arb_tagq.sv
// Two-entry owner-tag FIFO for reads awaiting completion.
module x_23K640_tagq #(
    parameter int TW = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          push,
    input  logic [TW-1:0] push_tag,
    input  logic          pop,
    output logic [TW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic          err
);
    logic [TW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & (~full | do_pop);
    assign err     = (push & full & ~pop) | (pop & empty);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/x_23k640_arb.sv
// Round-robin arbiter sharing one 23K640 SPI SRAM engine among N requesters.
// Optional burst lock: define X_23K640_ARB_BURST_LOCK_EN.
module x_23k640_arb
    import x_23K640_pkg::*;
#(
    parameter  int N  = 2,
    localparam int TW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N-1:0]        i_req_valid,
    output logic [N-1:0]        o_req_accept,
    input  logic [N-1:0]        i_req_rd_n_wr,
    input  logic [N*ADDR_W-1:0] i_req_addr,
    input  logic [N*DATA_W-1:0] i_req_wdata,
    output logic [N-1:0]        o_cpl_ready,
    output logic [DATA_W-1:0]   o_cpl_rdata,
    output logic                o_valid,
    output logic                o_rd_n_wr,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    input  logic                i_accept,
    input  logic                i_ready,
    input  logic [DATA_W-1:0]   i_rdata,
    output logic                o_err
);
    arb_state_t    state;
    arb_state_t    state_nxt;
    req_t          req_q;
    logic [TW-1:0] owner;
    logic [TW-1:0] last_owner;
    logic [TW-1:0] pick;
    logic          found;
    logic          grant;
    logic          accept_hold;
    logic          tq_push;
    logic [TW-1:0] tq_head;
    logic          tq_full;
    logic          tq_empty;
    logic          tq_err;
    logic          err_q;

    assign grant       = (state == ARB) & (|i_req_valid);
    assign accept_hold = i_accept & (state == HOLD);
    assign tq_push     = accept_hold & req_q.rd_n_wr;

`ifdef X_23K640_ARB_BURST_LOCK_EN
    logic [ADDR_W-1:0] last_addr;
    logic              last_rd_n_wr;
    logic              have_last;
    logic              locked_q;
    logic [5:0]        streak;
    logic              lock_ok;

    assign lock_ok = have_last
        & i_req_valid[last_owner]
        & (i_req_rd_n_wr[last_owner] == last_rd_n_wr)
        & (i_req_addr[ADDR_W*last_owner +: ADDR_W]
           == last_addr + 16'd1)
        & (streak < 6'(LOCK_MAX));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_addr    <= '0;
            last_rd_n_wr <= 1'b0;
            have_last    <= 1'b0;
            locked_q     <= 1'b0;
            streak       <= '0;
        end else begin
            if (grant) begin
                locked_q <= lock_ok;
            end
            if (accept_hold) begin
                last_addr    <= req_q.addr;
                last_rd_n_wr <= req_q.rd_n_wr;
                have_last    <= 1'b1;
                streak       <= locked_q ? streak + 6'd1 : 6'd1;
            end
        end
    end
`endif

    always_comb begin
        pick  = last_owner;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && i_req_valid[(int'(last_owner) + k) % N]) begin
                pick  = TW'((int'(last_owner) + k) % N);
                found = 1'b1;
            end
        end
`ifdef X_23K640_ARB_BURST_LOCK_EN
        if (lock_ok) begin
            pick = last_owner;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB:     if (|i_req_valid) state_nxt = HOLD;
            HOLD:    if (i_accept) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_q      <= '0;
            owner      <= '0;
            last_owner <= TW'(N - 1);
            err_q      <= 1'b0;
        end else begin
            if (grant) begin
                owner         <= pick;
                req_q.rd_n_wr <= i_req_rd_n_wr[pick];
                req_q.addr    <= i_req_addr[ADDR_W*pick +: ADDR_W];
                req_q.wdata   <= i_req_wdata[DATA_W*pick +: DATA_W];
            end
            if (accept_hold) begin
                last_owner <= owner;
            end
            // Overflow is also caught inside the queue; kept explicit here.
            if (tq_err | (i_accept & (state == ARB))
                | (tq_push & tq_full & ~i_ready)) begin
                err_q <= 1'b1;
            end
        end
    end

    x_23K640_tagq #(.TW(TW)) u_tagq (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (tq_push),
        .push_tag (owner),
        .pop      (i_ready),
        .head     (tq_head),
        .full     (tq_full),
        .empty    (tq_empty),
        .err      (tq_err)
    );

    always_comb begin
        o_req_accept = '0;
        o_cpl_ready  = '0;
        for (int i = 0; i < N; i++) begin
            o_req_accept[i] = accept_hold & (owner == TW'(i));
            o_cpl_ready[i]  = i_ready & ~tq_empty & (tq_head == TW'(i));
        end
    end

    assign o_cpl_rdata = i_rdata;
    assign o_valid     = (state == HOLD);
    assign o_rd_n_wr   = req_q.rd_n_wr;
    assign o_addr      = req_q.addr;
    assign o_wdata     = req_q.wdata;
    assign o_err       = err_q;
endmodule

// File: tb/tb_x_23k640_arb.sv
// Directed self-checking bench for x_23k640_arb with two requesters.
module tb_x_23k640_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_accept;
    logic [1:0]  req_rd;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  cpl_ready;
    logic [7:0]  cpl_rdata;
    logic        v;
    logic        rdw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        acc;
    logic        rdy;
    logic [7:0]  rdata;
    logic        err;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    x_23k640_arb #(.N(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_accept  (req_accept),
        .i_req_rd_n_wr (req_rd),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_cpl_ready   (cpl_ready),
        .o_cpl_rdata   (cpl_rdata),
        .o_valid       (v),
        .o_rd_n_wr     (rdw),
        .o_addr        (addr),
        .o_wdata       (wdata),
        .i_accept      (acc),
        .i_ready       (rdy),
        .i_rdata       (rdata),
        .o_err         (err)
    );

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_addr  = '0;
        req_wdata = '0;
        acc       = 1'b0;
        rdy       = 1'b0;
        rdata     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (v !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got=%b want=0", v);
        end
        n_cmp++;
        if ({rdw, addr, wdata} !== 25'd0) begin
            n_bad++; $display("FAIL reset_fields got=%h want=0", {rdw, addr, wdata});
        end
        n_cmp++;
        if ({req_accept, cpl_ready, err} !== 5'd0) begin
            n_bad++; $display("FAIL reset_strobes got=%b want=0", {req_accept, cpl_ready, err});
        end
    endtask

    task automatic test_single_read;
        req_valid       = 2'b10;
        req_rd          = 2'b10;
        req_addr[31:16] = 16'h0010;
        @(negedge clk);
        n_cmp++;
        if ({v, rdw, addr} !== {1'b1, 1'b1, 16'h0010}) begin
            n_bad++; $display("FAIL rd_issue got=%b/%b/%h want=1/1/0010", v, rdw, addr);
        end
        acc = 1'b1;
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (req_accept !== 2'b10) begin
            n_bad++; $display("FAIL rd_accept got=%b want=10", req_accept);
        end
        @(negedge clk);
        acc = 1'b0;
        n_cmp++;
        if (v !== 1'b0) begin
            n_bad++; $display("FAIL rd_gap got=%b want=0", v);
        end
        @(negedge clk);
        rdy   = 1'b1;
        rdata = 8'hA5;
        #1;
        n_cmp++;
        if ({cpl_ready, cpl_rdata} !== {2'b10, 8'hA5}) begin
            n_bad++; $display("FAIL rd_cpl got=%b/%h want=10/a5", cpl_ready, cpl_rdata);
        end
        @(negedge clk);
        rdy = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL rd_err got=%b want=0", err);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_acc [4];
        exp_acc = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        req_valid = 2'b11;
        req_rd    = 2'b00;
        req_addr  = {16'h0200, 16'h0100};
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            acc = 1'b1;
            #1;
            n_cmp++;
            if (req_accept !== exp_acc[g]) begin
                n_bad++; $display("FAIL rr_grant%0d got=%b want=%b", g, req_accept, exp_acc[g]);
            end
            if (g == 3) req_valid = 2'b00;
            @(negedge clk);
            acc = 1'b0;
        end
    endtask

    task automatic test_burst_lock;
        logic [1:0]  exp2;
        logic [15:0] exp_addr;
`ifdef X_23K640_ARB_BURST_LOCK_EN
        exp2     = 2'b01;
        exp_addr = 16'h0100;
`else
        exp2     = 2'b10;
        exp_addr = 16'h0500;
`endif
        do_reset();
        req_valid = 2'b11;
        req_rd    = 2'b11;
        req_addr  = {16'h0500, 16'h00FF};
        @(negedge clk);
        n_cmp++;
        if (addr !== 16'h00FF) begin
            n_bad++; $display("FAIL lock_first_addr got=%h want=00ff", addr);
        end
        acc = 1'b1;
        #1;
        n_cmp++;
        if (req_accept !== 2'b01) begin
            n_bad++; $display("FAIL lock_first got=%b want=01", req_accept);
        end
        req_addr[15:0] = 16'h0100;
        @(negedge clk);
        acc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (addr !== exp_addr) begin
            n_bad++; $display("FAIL lock_second_addr got=%h want=%h", addr, exp_addr);
        end
        acc = 1'b1;
        #1;
        n_cmp++;
        if (req_accept !== exp2) begin
            n_bad++; $display("FAIL lock_second got=%b want=%b", req_accept, exp2);
        end
        req_valid = 2'b00;
        @(negedge clk);
        acc   = 1'b0;
        rdy   = 1'b1;
        rdata = 8'h11;
        #1;
        n_cmp++;
        if (cpl_ready !== 2'b01) begin
            n_bad++; $display("FAIL lock_cpl1 got=%b want=01", cpl_ready);
        end
        @(negedge clk);
        rdata = 8'h22;
        #1;
        n_cmp++;
        if (cpl_ready !== exp2) begin
            n_bad++; $display("FAIL lock_cpl2 got=%b want=%b", cpl_ready, exp2);
        end
        @(negedge clk);
        rdy = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL lock_err got=%b want=0", err);
        end
    endtask

    task automatic test_hop;
        do_reset();
        req_valid = 2'b01;
        req_rd    = 2'b11;
        req_addr  = {16'h0030, 16'h0020};
        @(negedge clk);
        acc       = 1'b1;
        req_valid = 2'b10;
        @(negedge clk);
        acc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({v, addr} !== {1'b1, 16'h0030}) begin
            n_bad++; $display("FAIL hop_issue got=%b/%h want=1/0030", v, addr);
        end
        acc       = 1'b1;
        rdy       = 1'b1;
        rdata     = 8'h3C;
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if ({req_accept, cpl_ready, cpl_rdata} !== {2'b10, 2'b01, 8'h3C}) begin
            n_bad++; $display("FAIL hop_same_cycle got=%b/%b/%h want=10/01/3c",
                              req_accept, cpl_ready, cpl_rdata);
        end
        @(negedge clk);
        acc = 1'b0;
        rdy = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL hop_err got=%b want=0", err);
        end
        @(negedge clk);
        rdy   = 1'b1;
        rdata = 8'h77;
        #1;
        n_cmp++;
        if ({cpl_ready, cpl_rdata} !== {2'b10, 8'h77}) begin
            n_bad++; $display("FAIL hop_second_cpl got=%b/%h want=10/77", cpl_ready, cpl_rdata);
        end
        @(negedge clk);
        rdy = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL hop_drain_err got=%b want=0", err);
        end
    endtask

    task automatic test_write;
        req_valid        = 2'b10;
        req_rd           = 2'b00;
        req_addr[31:16]  = 16'h1234;
        req_wdata[15:8]  = 8'h5A;
        @(negedge clk);
        n_cmp++;
        if ({v, rdw, addr, wdata} !== {1'b1, 1'b0, 16'h1234, 8'h5A}) begin
            n_bad++; $display("FAIL wr_issue got=%b/%b/%h/%h want=1/0/1234/5a", v, rdw, addr, wdata);
        end
        acc       = 1'b1;
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if ({req_accept, cpl_ready} !== {2'b10, 2'b00}) begin
            n_bad++; $display("FAIL wr_accept got=%b/%b want=10/00", req_accept, cpl_ready);
        end
        @(negedge clk);
        acc = 1'b0;
    endtask

    task automatic test_underflow;
        rdy = 1'b1;
        #1;
        n_cmp++;
        if (cpl_ready !== 2'b00) begin
            n_bad++; $display("FAIL uf_cpl got=%b want=00", cpl_ready);
        end
        @(negedge clk);
        rdy = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL uf_err got=%b want=1", err);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL uf_sticky got=%b want=1", err);
        end
    endtask

    task automatic test_reset_mid_hold;
        do_reset();
        req_valid = 2'b01;
        req_rd    = 2'b11;
        req_addr  = {16'h0050, 16'h0040};
        @(negedge clk);
        acc       = 1'b1;
        req_valid = 2'b10;
        @(negedge clk);
        acc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (v !== 1'b1) begin
            n_bad++; $display("FAIL mid_hold_valid got=%b want=1", v);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({v, err} !== 2'b00) begin
            n_bad++; $display("FAIL async_reset got=%b/%b want=0/0", v, err);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        n_cmp++;
        if (cpl_ready !== 2'b00) begin
            n_bad++; $display("FAIL reset_discard got=%b want=00", cpl_ready);
        end
        @(negedge clk);
        rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_lock();
        test_hop();
        test_write();
        test_underflow();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/x_23k640_arb.md
# x_23K640_arb

Round-robin arbiter sharing one 23K640 SPI SRAM data engine between N application requesters. It sits between the requesters and the engine's request/completion ports. It selects one requester, holds its request stable on the engine port until the engine accepts, and routes each read completion back to the requester that issued it. An optional burst lock keeps ownership across sequential-address accesses, so the engine can chain them without de-asserting chip select.

## Interface
- N, default 2: number of requesters (2..8).
- TW, default $clog2(N): owner tag width (derived, not overridden).
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  N  per-requester request valid; held until own accept.
- o_req_accept  out  N  one-hot accept pulse to the owner.
- i_req_rd_n_wr  in  N  per-requester 1=read, 0=write.
- i_req_addr  in  N*16  per-requester address; slice i is [16*i+:16].
- i_req_wdata  in  N*8  per-requester write data.
- o_cpl_ready  out  N  one-hot read-completion pulse.
- o_cpl_rdata  out  8  read data, shared by all requesters; valid with o_cpl_ready.
- o_valid, o_rd_n_wr, o_addr[16], o_wdata[8]  out  engine request port.
- i_accept  in  1  engine accept pulse.
- i_ready  in  1  engine read-completion pulse.
- i_rdata  in  8  engine read data.
- o_err  out  1  sticky protocol error flag.

## Operation
- Arbiter FSM has two states:
  - ARB: o_valid=0. If any i_req_valid is set, pick the owner, register it plus its rd_n_wr/addr/wdata, and go to HOLD.
  - HOLD: o_valid=1; registered request fields are frozen. On i_accept, go to ARB.
- Round-robin search starts at last_owner+1 mod N. last_owner updates on every i_accept.
- o_req_accept[i] = i_accept & (owner==i), combinational.
- On i_accept with o_rd_n_wr=1, the owner tag is pushed into the tag queue.
- Tag queue is a 2-entry FIFO: one read in flight plus one read accepted at the hop point.
- On i_ready, the head tag is popped and o_cpl_ready[head]=1. o_cpl_rdata = i_rdata, combinational passthrough.
- Push and pop in the same cycle (engine hop at end of read) are both honoured; occupancy is unchanged.
- o_err sets on any of:
  - push while full without a simultaneous pop;
  - i_ready while empty (no pop occurs);
  - i_accept while in ARB.
- o_err clears only on reset.
- Writes produce no completion.
- last_addr (16b) and last_rd_n_wr record the most recent accepted request. Hop-eligible means same rd_n_wr and addr == last_addr+1, with 16-bit wrap: FFFF -> 0000 is eligible.

## Timing
- Reset values:
  - state ARB; o_valid=0; o_rd_n_wr=0, o_addr=0, o_wdata=0;
  - o_req_accept=0, o_cpl_ready=0, o_err=0;
  - last_owner=N-1, so requester 0 wins first; tag queue empty.
- Request latency: requester valid in cycle t gives o_valid=1 in t+1, provided the arbiter is in ARB.
- Minimum re-arbitration gap: o_valid is low for exactly one cycle after i_accept, then the next owner is driven.
- A requester must not change its fields while its valid is set and unaccepted. The arbiter samples them once, at grant.
- Dropping i_req_valid after grant does not withdraw the registered request; it completes normally.
- Completion routing has zero latency from i_ready.
- Reset mid-transfer: all state is cleared, in-flight tags are discarded, and no completion pulse is emitted afterwards.

## Configuration
- X_23K640_ARB_BURST_LOCK_EN defined:
  - in ARB, if last_owner is valid and hop-eligible, it wins regardless of the round-robin pointer;
  - the pointer is not advanced past it;
  - a lock streak is capped at 32 consecutive grants, after which normal round-robin applies for one grant.
- Undefined: pure round-robin; no last_addr comparison logic is built.

## Structure
- Package x_23K640_pkg holds:
  - ADDR_W=16, DATA_W=8;
  - arbiter state enum arb_state_t {ARB, HOLD};
  - packed struct req_t {rd_n_wr, addr, wdata}.
- Sub-module x_23K640_tagq: 2-entry FIFO of TW-bit tags with push, pop, head, full, empty and an overflow/underflow strobe.

## Test plan
- Reset, then only requester 1 issues read 0x0010 -> o_valid in next cycle with o_addr=0x0010. On i_accept, o_req_accept=2'b10. A later i_ready with i_rdata=0xA5 -> o_cpl_ready=2'b10, o_cpl_rdata=0xA5.
- Both requesters valid from reset -> grant order 0,1,0,1 across four accepts.
- Burst lock on: requester 0 reads 0x00FF then 0x0100 while requester 1 is waiting -> requester 0 granted twice in a row. Lock off -> requester 1 is granted in between.
- Hop: accept of read B coincides with i_ready of read A (same cycle) -> A completes to its owner, B's tag is queued, queue occupancy stays 1, o_err=0.
- Writes to 0x1234 with data 0x5A from requester 1 -> engine port shows 0x1234/0x5A/rd_n_wr=0; no o_cpl_ready pulse.
- i_ready with empty queue -> o_err=1 and stays 1 until reset. Assert i_rst mid-HOLD -> o_valid=0 asynchronously.
